// File: rtl/cordic_pipe.sv
// rtl/cordic_pipe.sv - pipelined CORDIC rotator/vectorer with quadrant pre-fold
// One sample per cycle; the whole pipe stalls together when the output is held.
module cordic_pipe #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 6,
  parameter int ITER  = 8,
  parameter int GUARD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic                    ovf,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int XW   = WIDTH + GUARD + 2;
  localparam int ZW   = WIDTH + GUARD + 1;
  localparam int FB   = FRAC + GUARD;
  localparam int RXW  = XW - GUARD;
  localparam int HALF = 2 ** (GUARD - 1);
  localparam real PI_R = 3.14159265358979323846;
  localparam logic signed [ZW-1:0] PI_C      = ZW'($rtoi(PI_R * (2.0 ** FB) + 0.5));
  localparam logic signed [ZW-1:0] HALF_PI_C = ZW'($rtoi(PI_R / 2.0 * (2.0 ** FB) + 0.5));
  localparam logic signed [WIDTH-1:0] OMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] OMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [RXW-1:0]   RMAX = RXW'(OMAX);
  localparam logic signed [RXW-1:0]   RMIN = RXW'(OMIN);

  // Round half away from zero while dropping the guard bits.
  function automatic logic signed [RXW-1:0] rnd(input logic signed [XW-1:0] v);
    return RXW'((v + (v[XW-1] ? XW'(HALF - 1) : XW'(HALF))) >>> GUARD);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [RXW-1:0] r);
    if (r > RMAX)      return OMAX;
    else if (r < RMIN) return OMIN;
    else               return r[WIDTH-1:0];
  endfunction

  logic signed [XW-1:0] r_x [0:ITER];
  logic signed [XW-1:0] r_y [0:ITER];
  logic signed [ZW-1:0] r_z [0:ITER];
  logic [ITER:0]        r_v;
  logic [ITER-1:0]      r_m;

  logic                 w_adv;
  logic signed [XW-1:0] w_xs, w_ys, w_fx, w_fy;
  logic signed [ZW-1:0] w_zs, w_fz;
  logic signed [XW-1:0] w_nx [ITER];
  logic signed [XW-1:0] w_ny [ITER];
  logic signed [ZW-1:0] w_nz [ITER];
  logic [ITER-1:0]      w_d;
  logic signed [RXW-1:0]   w_xr, w_yr, w_zr;
  logic signed [WIDTH-1:0] w_xo, w_yo, w_zo;
  logic                    w_xsat, w_ysat;

  assign w_adv    = !(out_valid && !out_ready);
  assign in_ready = w_adv;

  assign w_xs = {{2{x_in[WIDTH-1]}}, x_in, {GUARD{1'b0}}};
  assign w_ys = {{2{y_in[WIDTH-1]}}, y_in, {GUARD{1'b0}}};
  assign w_zs = {z_in[WIDTH-1], z_in, {GUARD{1'b0}}};

  // Fold into the right half-plane so the micro-rotations can converge.
  always_comb begin
    w_fx = w_xs;
    w_fy = w_ys;
    w_fz = w_zs;
    if (!mode) begin
      if (w_zs > HALF_PI_C) begin
        w_fx = -w_xs;
        w_fy = -w_ys;
        w_fz = w_zs - PI_C;
      end else if (w_zs < -HALF_PI_C) begin
        w_fx = -w_xs;
        w_fy = -w_ys;
        w_fz = w_zs + PI_C;
      end
    end else if (x_in[WIDTH-1]) begin
      w_fx = -w_xs;
      w_fy = -w_ys;
      w_fz = y_in[WIDTH-1] ? w_zs - PI_C : w_zs + PI_C;
    end
  end

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    localparam logic signed [ZW-1:0] ATAN = ZW'($rtoi($atan(2.0 ** (-i)) * (2.0 ** FB) + 0.5));
    assign w_d[i]  = r_m[i] ? r_y[i][XW-1] : ~r_z[i][ZW-1];
    assign w_nx[i] = w_d[i] ? r_x[i] - (r_y[i] >>> i) : r_x[i] + (r_y[i] >>> i);
    assign w_ny[i] = w_d[i] ? r_y[i] + (r_x[i] >>> i) : r_y[i] - (r_x[i] >>> i);
    assign w_nz[i] = w_d[i] ? r_z[i] - ATAN : r_z[i] + ATAN;
  end

  assign w_xr   = rnd(r_x[ITER]);
  assign w_yr   = rnd(r_y[ITER]);
  assign w_zr   = rnd({r_z[ITER][ZW-1], r_z[ITER]});
  assign w_xo   = sat(w_xr);
  assign w_yo   = sat(w_yr);
  assign w_zo   = sat(w_zr);
  assign w_xsat = (w_xr != RXW'(w_xo));
  assign w_ysat = (w_yr != RXW'(w_yo));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v       <= '0;
      r_m       <= '0;
      for (int k = 0; k <= ITER; k++) begin
        r_x[k] <= '0;
        r_y[k] <= '0;
        r_z[k] <= '0;
      end
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (w_adv) begin
      r_v[0] <= in_valid;
      r_m[0] <= mode;
      r_x[0] <= w_fx;
      r_y[0] <= w_fy;
      r_z[0] <= w_fz;
      for (int i = 0; i < ITER; i++) begin
        r_v[i+1] <= r_v[i];
        r_x[i+1] <= w_nx[i];
        r_y[i+1] <= w_ny[i];
        r_z[i+1] <= w_nz[i];
      end
      for (int i = 1; i < ITER; i++) begin
        r_m[i] <= r_m[i-1];
      end
      x_out     <= w_xo;
      y_out     <= w_yo;
      z_out     <= w_zo;
      ovf       <= r_v[ITER] & (w_xsat | w_ysat);
      out_valid <= r_v[ITER];
    end
  end

endmodule

// File: tb/tb_cordic_pipe.sv
// tb/tb_cordic_pipe.sv - scoreboard bench for cordic_pipe against a real-valued model
module tb_cordic_pipe;
  localparam int ITER = 8;

  logic clk = 1'b0;
  logic rst, mode, in_valid, out_ready;
  logic signed [7:0] x_in, y_in, z_in;
  logic in_ready, ovf, out_valid;
  logic signed [7:0] x_out, y_out, z_out;

  typedef struct packed {
    int   x; int y; int z;
    int   tx; int ty; int tz;
    logic ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  real  K;
  logic prev_stall = 1'b0;
  logic signed [7:0] hx, hy, hz;

  always #5 clk = ~clk;

  cordic_pipe #(.WIDTH(8), .FRAC(6), .ITER(ITER), .GUARD(4)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = obs - exp;
    if (d < 0) d = -d;
    checks++;
    assert (d <= tol) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  function automatic int rnd_away(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic int clamp(input int v, output int tol);
    tol = 2;
    if (v > 127)  begin tol = 0; return 127;  end
    if (v < -128) begin tol = 0; return -128; end
    return v;
  endfunction

  function automatic exp_t model(input logic m, input int x, input int y, input int z);
    exp_t e;
    real  rx, ry, rz, a;
    int   t;
    if (!m) begin
      a  = z / 64.0;
      rx = K * (x * $cos(a) - y * $sin(a));
      ry = K * (x * $sin(a) + y * $cos(a));
      rz = 0.0;
    end else begin
      rx = K * $sqrt(real'(x * x + y * y));
      ry = 0.0;
      rz = z + 64.0 * $atan2(real'(y), real'(x));
    end
    e.x = clamp(rnd_away(rx), t); e.tx = t;
    e.y = clamp(rnd_away(ry), t); e.ty = t;
    e.z = clamp(rnd_away(rz), t); e.tz = t;
    e.ovf = (e.tx == 0) || (e.ty == 0);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_x", x_out, hx, 0);
        chk("stall_hold_y", y_out, hy, 0);
        chk("stall_hold_z", z_out, hz, 0);
      end
      prev_stall = out_valid && !out_ready;
      hx = x_out; hy = y_out; hz = z_out;
      if (out_valid && out_ready) begin
        chk("output_expected", q.size(), 1, 1000000);
        if (q.size() == 0) begin
          failures++;
          $error("FAIL unexpected_output observed=out_valid expected=no output");
        end else begin
          e = q.pop_front();
          pops++;
          chk("x_out", x_out, e.x, e.tx);
          chk("y_out", y_out, e.y, e.ty);
          chk("z_out", z_out, e.z, e.tz);
          chk("ovf", ovf, e.ovf, 0);
        end
      end
      if (in_valid && in_ready) q.push_back(model(mode, x_in, y_in, z_in));
    end
  end

  task automatic drive(input logic m, input int x, input int y, input int z);
    int   n;
    logic ok;
    mode = m; x_in = 8'(x); y_in = 8'(y); z_in = 8'(z);
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n > 50) begin
        failures++;
        $error("FAIL drive_timeout observed=in_ready low expected=accept within 50 cycles");
        break;
      end
    end
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int cnt;
    cnt = 1;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      cnt++;
      if (cnt > 40) break;
    end
    chk(tag, cnt, exp_lat, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=still running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sm[12];
    int   sx[12], sy[12], sz[12];
    int   seen;

    K = 1.0;
    for (int i = 0; i < ITER; i++) K = K * $sqrt(1.0 + 2.0 ** (-2 * i));

    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1;
    x_in = '0; y_in = '0; z_in = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0, 0);
    chk("rst_ovf", ovf, 0, 0);
    chk("rst_x_out", x_out, 0, 0);
    chk("rst_y_out", y_out, 0, 0);
    chk("rst_z_out", z_out, 0, 0);
    chk("rst_in_ready", in_ready, 1, 0);
    rst = 1'b0;

    drive(1'b0, 39, 0, 43);    in_valid = 1'b0; wait_out("lat_first", 10);
    drive(1'b0, 39, 0, 120);   in_valid = 1'b0; wait_out("lat_fold_pos", 10);
    drive(1'b0, 39, 0, -120);  in_valid = 1'b0; wait_out("lat_fold_neg", 10);
    drive(1'b1, 32, 32, 0);    in_valid = 1'b0; wait_out("lat_vec", 10);
    drive(1'b1, -32, 10, -100); in_valid = 1'b0; wait_out("lat_vec_fold", 10);
    drive(1'b0, 127, 127, 0);  in_valid = 1'b0; wait_out("lat_sat", 10);

    for (int i = 0; i < 12; i++) begin
      sm[i] = 1'($urandom_range(1));
      sy[i] = int'($urandom_range(80)) - 40;
      if (!sm[i]) begin
        sx[i] = int'($urandom_range(80)) - 40;
        sz[i] = int'($urandom_range(255)) - 128;
      end else begin
        sx[i] = int'($urandom_range(40, 1));
        sz[i] = int'($urandom_range(40)) - 20;
      end
    end
    for (int i = 0; i < 10; i++) drive(sm[i], sx[i], sy[i], sz[i]);
    out_ready = 1'b0;
    mode = sm[10]; x_in = 8'(sx[10]); y_in = 8'(sy[10]); z_in = 8'(sz[10]);
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0, 0);
      chk("stall_out_valid", out_valid, 1, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drive(sm[10], sx[10], sy[10], sz[10]);
    drive(sm[11], sx[11], sy[11], sz[11]);
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("burst_pops", pops, 18, 0);
    chk("burst_queue_empty", q.size(), 0, 0);

    for (int i = 0; i < 5; i++) drive(1'b0, 20 + i, 5, 10 * i);
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("pre_rst_out_valid", out_valid, 1, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0, 0);
    chk("async_rst_x_out", x_out, 0, 0);
    chk("async_rst_y_out", y_out, 0, 0);
    chk("async_rst_z_out", z_out, 0, 0);
    chk("async_rst_ovf", ovf, 0, 0);
    chk("async_rst_in_ready", in_ready, 1, 0);
    q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("post_rst_quiet", seen, 0, 0);
    @(posedge clk); #1;
    drive(1'b0, 39, 0, 43); in_valid = 1'b0; wait_out("lat_after_rst", 10);
    repeat (3) @(posedge clk);
    #1;
    chk("total_pops", pops, 19, 0);
    chk("final_queue_empty", q.size(), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
